// File: rtl/arb_client_pkg.sv
// arb_client_pkg: FSM state encoding and command length width shared by arbiter clients
package arb_client_pkg;

   localparam int LEN_W = 4;

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

endpackage

// File: rtl/arb_client_fifo.sv
// arb_client_fifo: DEPTH-entry synchronous FIFO of burst lengths with occupancy count
module arb_client_fifo
   import arb_client_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [LEN_W-1:0] din,
   input  logic             pop,
   output logic [LEN_W-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [LEN_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage needs no reset: only pointers and count say what is valid
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   // pointers wrap on their own because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/arb_client.sv
// arb_client: queues burst commands and plays them out as beats through one arbiter port
module arb_client
   import arb_client_pkg::*;
#(
   parameter  int DEPTH   = 4,
   parameter  int TIMEOUT = 255,
   localparam int OW      = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             req,
   input  logic             grant,
   output logic             beat_valid,
   output logic [LEN_W-1:0] beat_idx,
   output logic             beat_last,
   output logic [OW-1:0]    occupancy,
   output logic             starve_err,
   output logic             spurious_err
);

   localparam int            WW       = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

   state_t           state;
   logic [LEN_W-1:0] len, cnt, head;
   logic [WW-1:0]    wait_cnt;
   logic             full, empty, pop, in_beat;

   assign cmd_ready  = !full;
   assign pop        = state == IDLE && !empty;
   assign in_beat    = state == XFER && grant;
   assign beat_valid = in_beat;
   assign beat_idx   = cnt;
   assign beat_last  = in_beat && cnt == len;

   arb_client_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .din   (cmd_len),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (occupancy)
   );

   // burst sequencer: pop, request, stream beats while granted, one idle gap cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         len   <= '0;
         cnt   <= '0;
         req   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (!empty) begin
               len   <= head;
               req   <= 1'b1;
               state <= REQ;
            end
            REQ: if (grant) begin
               cnt   <= '0;
               state <= XFER;
            end
            XFER: if (grant) begin
               cnt <= cnt == len ? '0 : cnt + 1'b1;
               if (cnt == len) begin
                  req   <= 1'b0;
                  state <= GAP;
               end
            end
            GAP: state <= IDLE;
         endcase
      end
   end

   // ungranted REQ cycles, saturating, restarted whenever REQ is left or granted
   always_ff @(posedge clk) begin
      if (!rst_n || state != REQ || grant) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
   end

   // sticky protocol error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_err   <= 1'b0;
         spurious_err <= 1'b0;
      end else begin
         if (state == REQ && !grant && wait_cnt >= WAIT_MAX - 1'b1) starve_err <= 1'b1;
         if (grant && !req) spurious_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arb_client.sv
// tb_arb_client: directed and randomized scoreboard bench for arb_client
module tb_arb_client;
   import arb_client_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 10;
   localparam int OW      = $clog2(DEPTH) + 1;

   typedef struct {
      logic [3:0] idx;
      logic       last;
   } beat_t;

   logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, grant = 1'b0;
   logic [3:0]    cmd_len = '0;
   logic          cmd_ready, req, beat_valid, beat_last, starve_err, spurious_err;
   logic [3:0]    beat_idx;
   logic [OW-1:0] occupancy;

   int    checks = 0, failures = 0;
   beat_t exp_q[$];
   beat_t mon_e;
   int    outstanding = 0;
   int    after_last = 0;
   int    gmode = 0;
   logic  man_grant = 1'b0;
   logic  req_prev = 1'b0;
   int    zeros = 0;

   arb_client #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_len      (cmd_len),
      .req          (req),
      .grant        (grant),
      .beat_valid   (beat_valid),
      .beat_idx     (beat_idx),
      .beat_last    (beat_last),
      .occupancy    (occupancy),
      .starve_err   (starve_err),
      .spurious_err (spurious_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   // arbiter model: 0 never grants, 1 grants one cycle after req rises, 2 random, 3 manual
   always @(negedge clk) begin
      case (gmode)
         0: grant = 1'b0;
         1: grant = req && req_prev;
         2: begin
            grant = req && (zeros >= 4 || $urandom_range(0, 3) != 0);
            zeros = (req && !grant) ? zeros + 1 : 0;
         end
         default: grant = man_grant;
      endcase
      req_prev = req;
   end

   // monitor: records accepted commands as expected beats and checks every issued beat
   always begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
         exp_q.delete();
         outstanding = 0;
         after_last  = 0;
      end else begin
         if (after_last > 0) begin
            check("req_low_after_last", req, 0);
            after_last--;
         end
         if (beat_valid) begin
            check("beat_needs_grant", grant, 1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got idx %0d expected no beat", beat_idx);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_idx", beat_idx, mon_e.idx);
               check("beat_last", beat_last, mon_e.last);
               if (mon_e.last) begin
                  outstanding--;
                  after_last = 2;
               end
            end
         end else check("last_without_valid", beat_last, 0);
         if (cmd_valid && outstanding < DEPTH) check("cmd_ready_room", cmd_ready, 1);
         check("occupancy_bound", 32'(int'(occupancy) <= outstanding), 1);
         if (cmd_valid && cmd_ready) begin
            for (int i = 0; i <= int'(cmd_len); i++) begin
               mon_e.idx  = 4'(i);
               mon_e.last = i == int'(cmd_len);
               exp_q.push_back(mon_e);
            end
            outstanding++;
         end
      end
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      man_grant = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_req", req, 0);
      check("rst_beat_valid", beat_valid, 0);
      check("rst_beat_idx", beat_idx, 0);
      check("rst_beat_last", beat_last, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_starve", starve_err, 0);
      check("rst_spurious", spurious_err, 0);
   endtask

   task automatic offer(input logic [3:0] l);
      cmd_valid = 1'b1;
      cmd_len   = l;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int lim, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || after_last != 0) && n < lim) begin
         tick();
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!req && n < 10) begin
         tick();
         n++;
      end
      check({name, "_req_up"}, req, 1);
   endtask

   initial begin
      int n, nb, lows, drop;
      // single burst, grant follows req by one cycle
      gmode = 1;
      do_reset();
      cmd_valid = 1'b1;
      cmd_len   = 4'd3;
      check("t1_req_push_cycle", req, 0);
      tick();
      cmd_valid = 1'b0;
      check("t1_occ_after_push", occupancy, 1);
      check("t1_req_pop_cycle", req, 0);
      tick();
      check("t1_req_after_pop", req, 1);
      check("t1_occ_after_pop", occupancy, 0);
      drain(50, "t1");
      check("t1_req_idle", req, 0);
      // fill the FIFO while the arbiter never grants
      gmode = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1;
         cmd_len   = 4'(i + 1);
         check("t2_ready", 32'(i < 5), cmd_ready);
         tick();
      end
      cmd_valid = 1'b0;
      check("t2_occ_full", occupancy, 4);
      check("t2_ready_full", cmd_ready, 0);
      check("t2_req_waiting", req, 1);
      gmode = 1;
      drain(200, "t2");
      check("t2_starve", starve_err, 0);
      check("t2_spurious", spurious_err, 0);
      // grant withdrawn for three cycles after beat 2
      gmode = 3;
      do_reset();
      offer(4'd7);
      wait_req("t3");
      man_grant = 1'b1;
      nb = 0;
      lows = 0;
      drop = 0;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (drop > 0) begin
            check("t3_hold_no_beat", beat_valid, 0);
            check("t3_hold_req", req, 1);
            lows++;
            drop--;
            if (drop == 0) man_grant = 1'b1;
         end else if (beat_valid) begin
            nb++;
            if (beat_idx == 4'd2 && lows == 0) begin
               man_grant = 1'b0;
               drop = 3;
            end
            if (beat_last) begin
               man_grant = 1'b0;
               break;
            end
         end
      end
      check("t3_beats", nb, 8);
      check("t3_gap_cycles", lows, 3);
      drain(20, "t3");
      // starvation after TIMEOUT ungranted REQ cycles
      gmode = 3;
      do_reset();
      offer(4'd0);
      wait_req("t4");
      for (int k = 1; k <= TIMEOUT; k++) begin
         check("t4_no_starve_yet", starve_err, 0);
         tick();
      end
      check("t4_starve", starve_err, 1);
      check("t4_still_req", req, 1);
      man_grant = 1'b1;
      n = 0;
      while (!beat_last && n < 10) begin
         tick();
         n++;
      end
      man_grant = 1'b0;
      check("t4_beat_seen", beat_last, 1);
      drain(20, "t4");
      check("t4_starve_sticky", starve_err, 1);
      check("t4_spurious", spurious_err, 0);
      // grant pulse with nothing requested
      gmode = 3;
      do_reset();
      man_grant = 1'b1;
      tick();
      man_grant = 1'b0;
      check("t5_no_beat_pulse", beat_valid, 0);
      check("t5_no_err_yet", spurious_err, 0);
      tick();
      check("t5_spurious", spurious_err, 1);
      check("t5_req", req, 0);
      repeat (3) tick();
      check("t5_spurious_sticky", spurious_err, 1);
      check("t5_occupancy", occupancy, 0);
      // reset in the middle of a burst with more commands queued
      gmode = 1;
      do_reset();
      offer(4'd5);
      offer(4'd2);
      offer(4'd9);
      n = 0;
      while (!(beat_valid && beat_idx == 4'd2) && n < 30) begin
         tick();
         n++;
      end
      check("t6_reached_beat2", 32'(beat_valid && beat_idx == 4'd2), 1);
      check("t6_occ_before", occupancy, 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_req", req, 0);
      check("t6_beat_valid", beat_valid, 0);
      check("t6_occupancy", occupancy, 0);
      check("t6_starve", starve_err, 0);
      check("t6_spurious", spurious_err, 0);
      repeat (12) begin
         tick();
         check("t6_abandoned", 32'(beat_valid || req), 0);
      end
      // randomized traffic against the scoreboard
      gmode = 2;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         cmd_valid = (outstanding < DEPTH) && ($urandom_range(0, 3) == 0);
         cmd_len   = 4'($urandom_range(0, 15));
         tick();
      end
      cmd_valid = 1'b0;
      drain(400, "t7");
      check("t7_starve", starve_err, 0);
      check("t7_spurious", spurious_err, 0);
      check("t7_occupancy", occupancy, 0);
      check("t7_req", req, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
